// File: rtl/vx_gpr_read_stage.sv
// vx_gpr_read_stage
// Per-warp general purpose register file with a small read sequencer.
// rs1/rs2 are read in one cycle through ports A and B. rs3, when the
// instruction needs it, is read through port A in the following cycle.
// The operand bundle is then held in output registers behind a valid/ready
// handshake. Writeback has its own lane-masked write port and is never
// stalled. A read that is launched in the same cycle as a write to the same
// {warp, reg} sees the new data on the written lanes (write-first bypass).
module vx_gpr_read_stage #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WID_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [WID_WIDTH-1:0]              req_wid,
    input  logic [4:0]                        req_rs1,
    input  logic [4:0]                        req_rs2,
    input  logic [4:0]                        req_rs3,
    input  logic                              req_use_rs3,
    input  logic                              wb_valid,
    input  logic [WID_WIDTH-1:0]              wb_wid,
    input  logic [4:0]                        wb_rd,
    input  logic [NUM_THREADS-1:0]            wb_tmask,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] wb_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] rsp_rs1_data,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] rsp_rs2_data,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] rsp_rs3_data
);

    localparam int VW    = NUM_THREADS * DATA_WIDTH;
    localparam int DEPTH = NUM_WARPS * NUM_REGS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R12  = 2'd1,
        R3   = 2'd2,
        RSP  = 2'd3
    } state_t;

    // Merges a freshly written word into a stored word lane by lane, and
    // forces register 0 to read as zero.
    function automatic logic [VW-1:0] read_merge_f(
        input logic [VW-1:0]          old_word,
        input logic [VW-1:0]          new_word,
        input logic [NUM_THREADS-1:0] mask,
        input logic                   hit,
        input logic                   is_zero_reg
    );
        logic [VW-1:0] res;
        res = old_word;
        for (int l = 0; l < NUM_THREADS; l++) begin
            if (hit && mask[l]) begin
                res[l*DATA_WIDTH +: DATA_WIDTH] = new_word[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (is_zero_reg) begin
            res = {VW{1'b0}};
        end
        return res;
    endfunction

    logic [VW-1:0]        gpr_mem_r [DEPTH];

    state_t               state_r;
    logic [WID_WIDTH-1:0] wid_r;
    logic [4:0]           rs3_idx_r;
    logic                 use_rs3_r;
    logic [VW-1:0]        rd_a_r;
    logic [VW-1:0]        rd_b_r;
    logic [VW-1:0]        rs1_r;
    logic [VW-1:0]        rs2_r;
    logic [VW-1:0]        rs3_r;
    logic                 rsp_valid_r;

    logic                 ready_s;
    logic                 accept_s;
    logic [WID_WIDTH-1:0] ra_wid_s;
    logic [4:0]           ra_reg_s;
    logic                 wb_en_s;
    logic                 hit_a_s;
    logic                 hit_b_s;

    // Request acceptance: idle, or handing off the current bundle this cycle.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = 1'b1;
            RSP:     ready_s = rsp_ready;
            default: ready_s = 1'b0;
        endcase
    end

    assign accept_s = req_valid & ready_s;

    // Port A address: rs3 of the latched request while in R12, else the new rs1.
    always_comb begin
        ra_wid_s = req_wid;
        ra_reg_s = req_rs1;
        if (state_r == R12) begin
            ra_wid_s = wid_r;
            ra_reg_s = rs3_idx_r;
        end else begin
            ra_wid_s = req_wid;
            ra_reg_s = req_rs1;
        end
    end

    assign wb_en_s = wb_valid && (wb_rd != 5'd0);
    assign hit_a_s = wb_en_s && (wb_wid == ra_wid_s) && (wb_rd == ra_reg_s);
    assign hit_b_s = wb_en_s && (wb_wid == req_wid) && (wb_rd == req_rs2);

    // Lane-masked writeback into the register array (contents are not reset).
    always_ff @(posedge clk) begin
        if (wb_en_s) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (wb_tmask[l]) begin
                    gpr_mem_r[{wb_wid, wb_rd}][l*DATA_WIDTH +: DATA_WIDTH] <= wb_data[l*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Synchronous read ports A and B with same-cycle write bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a_r <= {VW{1'b0}};
            rd_b_r <= {VW{1'b0}};
        end else begin
            rd_a_r <= read_merge_f(gpr_mem_r[{ra_wid_s, ra_reg_s}], wb_data, wb_tmask,
                                   hit_a_s, ra_reg_s == 5'd0);
            rd_b_r <= read_merge_f(gpr_mem_r[{req_wid, req_rs2}], wb_data, wb_tmask,
                                   hit_b_s, req_rs2 == 5'd0);
        end
    end

    // Read sequencer and registered operand bundle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            wid_r       <= {WID_WIDTH{1'b0}};
            rs3_idx_r   <= 5'd0;
            use_rs3_r   <= 1'b0;
            rs1_r       <= {VW{1'b0}};
            rs2_r       <= {VW{1'b0}};
            rs3_r       <= {VW{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wid_r     <= req_wid;
                        rs3_idx_r <= req_rs3;
                        use_rs3_r <= req_use_rs3;
                        state_r   <= R12;
                    end
                end
                R12: begin
                    rs1_r <= rd_a_r;
                    rs2_r <= rd_b_r;
                    if (use_rs3_r) begin
                        state_r <= R3;
                    end else begin
                        rs3_r       <= {VW{1'b0}};
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end
                end
                R3: begin
                    rs3_r       <= rd_a_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (req_valid) begin
                            wid_r     <= req_wid;
                            rs3_idx_r <= req_rs3;
                            use_rs3_r <= req_use_rs3;
                            state_r   <= R12;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = ready_s;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rs1_data = rs1_r;
    assign rsp_rs2_data = rs2_r;
    assign rsp_rs3_data = rs3_r;

endmodule

// File: tb/tb_vx_gpr_read_stage.sv
// tb_vx_gpr_read_stage
// Directed bench for vx_gpr_read_stage. A behavioural register-file model plus
// a queue of expected bundles tracks what the outputs must be; a negedge
// process compares the DUT against it every cycle, and the directed sequence
// adds hand-computed literal expectations.
module tb_vx_gpr_read_stage;

    logic         clk;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_wid;
    logic [4:0]   req_rs1;
    logic [4:0]   req_rs2;
    logic [4:0]   req_rs3;
    logic         req_use_rs3;
    logic         wb_valid;
    logic [1:0]   wb_wid;
    logic [4:0]   wb_rd;
    logic [3:0]   wb_tmask;
    logic [127:0] wb_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rs1_data;
    logic [127:0] rsp_rs2_data;
    logic [127:0] rsp_rs3_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    vx_gpr_read_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wid      (req_wid),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rs3      (req_rs3),
        .req_use_rs3  (req_use_rs3),
        .wb_valid     (wb_valid),
        .wb_wid       (wb_wid),
        .wb_rd        (wb_rd),
        .wb_tmask     (wb_tmask),
        .wb_data      (wb_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rs1_data (rsp_rs1_data),
        .rsp_rs2_data (rsp_rs2_data),
        .rsp_rs3_data (rsp_rs3_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [127:0] rs1;
        logic [127:0] rs2;
        logic [127:0] rs3;
        int           due;
    } bundle_t;

    logic [31:0] mem_m [4][32][4];
    bundle_t     q[$];
    logic        pend3 = 1'b0;
    logic [1:0]  pend_wid;
    logic [4:0]  pend_reg;

    function automatic logic [127:0] mread(input logic [1:0] w, input logic [4:0] r);
        logic [127:0] v;
        v = 128'd0;
        if (r != 5'd0) begin
            for (int l = 0; l < 4; l++) v[l*32 +: 32] = mem_m[w][r][l];
        end
        return v;
    endfunction

    initial begin
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++)
                for (int l = 0; l < 4; l++) mem_m[w][r][l] = 32'd0;
    end

    // Model update at each edge: writes land first, so reads in the same cycle see them.
    always @(posedge clk) begin
        bundle_t b;
        bundle_t nb;
        logic    head_due;
        logic    ready_m;
        if (!reset_n) begin
            q.delete();
            pend3 = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 5'd0)
                for (int l = 0; l < 4; l++)
                    if (wb_tmask[l]) mem_m[wb_wid][wb_rd][l] = wb_data[l*32 +: 32];
            if (pend3) begin
                b = q.pop_back();
                b.rs3 = mread(pend_wid, pend_reg);
                q.push_back(b);
                pend3 = 1'b0;
            end
            head_due = (q.size() > 0) && (q[0].due <= cyc);
            ready_m  = (q.size() == 0) || (head_due && rsp_ready);
            if (head_due && rsp_ready) void'(q.pop_front());
            if (req_valid && ready_m) begin
                nb.rs1 = mread(req_wid, req_rs1);
                nb.rs2 = mread(req_wid, req_rs2);
                nb.rs3 = 128'd0;
                nb.due = cyc + (req_use_rs3 ? 3 : 2);
                q.push_back(nb);
                if (req_use_rs3) begin
                    pend3    = 1'b1;
                    pend_wid = req_wid;
                    pend_reg = req_rs3;
                end
            end
        end
        cyc++;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic exp_v;
        logic exp_r;
        exp_v = reset_n && (q.size() > 0) && (q[0].due <= cyc);
        exp_r = !reset_n || (q.size() == 0) || (exp_v && rsp_ready);
        chk("model rsp_valid", 128'(rsp_valid), 128'(exp_v));
        chk("model req_ready", 128'(req_ready), 128'(exp_r));
        if (exp_v) begin
            chk("model rs1", rsp_rs1_data, q[0].rs1);
            chk("model rs2", rsp_rs2_data, q[0].rs2);
            chk("model rs3", rsp_rs3_data, q[0].rs3);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [1:0] w, input logic [4:0] rd, input logic [3:0] m, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_wid   = w;
        wb_rd    = rd;
        wb_tmask = m;
        wb_data  = {4{d}};
    endtask

    task automatic set_req(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3, input logic use3);
        req_valid   = 1'b1;
        req_wid     = 2'd1;
        req_rs1     = r1;
        req_rs2     = r2;
        req_rs3     = r3;
        req_use_rs3 = use3;
    endtask

    logic [127:0] mix_r5;

    initial begin
        mix_r5 = {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA};
        reset_n = 1'b0; req_valid = 1'b0; req_wid = 2'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
        req_rs3 = 5'd0; req_use_rs3 = 1'b0; wb_valid = 1'b0; wb_wid = 2'd0; wb_rd = 5'd0;
        wb_tmask = 4'd0; wb_data = 128'd0; rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset rsp_valid", 128'(rsp_valid), 128'd0);
        chk("reset rs1 zero", rsp_rs1_data, 128'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: two-operand read, response two cycles after acceptance
        set_wb(2'd1, 5'd5, 4'hF, 32'h11111111); tick();
        set_wb(2'd1, 5'd6, 4'hF, 32'h22222222); tick();
        wb_valid = 1'b0;
        set_req(5'd5, 5'd6, 5'd0, 1'b0); tick();
        req_valid = 1'b0;
        @(negedge clk); chk("t1 valid T+1", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk); chk("t1 valid T+2", 128'(rsp_valid), 128'd1);
        chk("t1 rs1", rsp_rs1_data, {4{32'h11111111}});
        chk("t1 rs2", rsp_rs2_data, {4{32'h22222222}});
        chk("t1 rs3", rsp_rs3_data, 128'd0);
        tick();

        // 2: three-operand read, response three cycles after acceptance
        set_wb(2'd1, 5'd7, 4'hF, 32'h33333333); tick();
        wb_valid = 1'b0;
        set_req(5'd5, 5'd6, 5'd7, 1'b1); tick();
        req_valid = 1'b0;
        @(negedge clk); chk("t2 valid T+1", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk); chk("t2 valid T+2", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk); chk("t2 valid T+3", 128'(rsp_valid), 128'd1);
        chk("t2 rs3", rsp_rs3_data, {4{32'h33333333}});
        chk("t2 rs1", rsp_rs1_data, {4{32'h11111111}});
        tick();

        // 3: writes to reg 0 are dropped, reg 0 reads as zero
        set_wb(2'd1, 5'd0, 4'hF, 32'hFFFFFFFF); tick();
        wb_valid = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 1'b0); tick();
        req_valid = 1'b0; tick();
        @(negedge clk);
        chk("t3 rs1 zero", rsp_rs1_data, 128'd0);
        chk("t3 rs2 zero", rsp_rs2_data, 128'd0);
        tick();

        // 4: same-cycle write bypass on masked lanes; later write not seen
        set_req(5'd5, 5'd6, 5'd0, 1'b0);
        set_wb(2'd1, 5'd5, 4'b0101, 32'hAAAAAAAA); tick();
        req_valid = 1'b0;
        set_wb(2'd1, 5'd6, 4'hF, 32'h66666666); tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("t4 rs1 bypass", rsp_rs1_data, mix_r5);
        chk("t4 rs2 old", rsp_rs2_data, {4{32'h22222222}});
        tick();

        // 5: back-pressure holds the bundle, then back-to-back acceptance
        rsp_ready = 1'b0;
        set_req(5'd5, 5'd6, 5'd0, 1'b0); tick();
        req_valid = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5 hold valid", 128'(rsp_valid), 128'd1);
            chk("t5 hold ready", 128'(req_ready), 128'd0);
            chk("t5 hold rs1", rsp_rs1_data, mix_r5);
            chk("t5 hold rs2", rsp_rs2_data, {4{32'h66666666}});
            tick();
        end
        rsp_ready = 1'b1;
        set_req(5'd6, 5'd5, 5'd0, 1'b0);
        @(negedge clk); chk("t5 b2b ready", 128'(req_ready), 128'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk); chk("t5 next T+1", 128'(rsp_valid), 128'd0);
        tick();
        @(negedge clk); chk("t5 next T+2", 128'(rsp_valid), 128'd1);
        chk("t5 next rs1", rsp_rs1_data, {4{32'h66666666}});
        tick();

        // 6: reset while reading rs3 drops the request
        set_req(5'd5, 5'd6, 5'd7, 1'b1); tick();
        req_valid = 1'b0; tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 reset valid", 128'(rsp_valid), 128'd0);
        chk("t6 reset rs3", rsp_rs3_data, 128'd0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6 post valid", 128'(rsp_valid), 128'd0);
            chk("t6 post ready", 128'(req_ready), 128'd1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
